// File: rtl/arm_mc_pkg.sv
// Shared types and constants for the multicycle ARM main sequencer.
// Optional build macro ARM_MC_MEM_WAIT_EN (used by arm_mc_main_fsm) adds memory wait states.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  // ALU operand B selects
  localparam logic [1:0] SRCB_RM  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  // Result bus selects
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Instruction class (instr[27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Per-state control word, before reset/wait gating
  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

  // States that touch the unified memory port and may stall on it
  function automatic logic is_mem_state(state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/arm_mc_out_decode.sv
// Pure combinational state -> control word decode for the multicycle sequencer.
module arm_mc_out_decode
  import arm_mc_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Moore decode; unreachable codes fall to an all-zero word
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_4;
        ctrl.result_src = RES_ALU;
      end
      DECODE: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_4;
        ctrl.result_src = RES_ALU;
      end
      MEMADR: ctrl.alu_src_b = SRCB_IMM;
      MEMRD:  ctrl.adr_src   = 1'b1;
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      MEMWR: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
      end
      EXECR: begin
        ctrl.alu_src_b = SRCB_RM;
        ctrl.alu_op    = 1'b1;
      end
      EXECI: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = 1'b1;
      end
      ALUWB:  ctrl.reg_w = 1'b1;
      BRANCH: begin
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.branch     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/arm_mc_main_fsm.sv
// Main sequencing FSM for the multicycle ARM datapath.
// Build macro ARM_MC_MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall until mem_ready, and
// IRWrite/NextPC/MemW fire only in the ready cycle. Undefined: mem_ready is ignored.
// illegal is a registered pulse: it is high for the one cycle after a DECODE of op=11.
module arm_mc_main_fsm
  import arm_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             NextPC,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;
  ctrl_t  ctrl;
  logic   mem_go;   // memory-port step may complete this cycle

  arm_mc_out_decode u_dec (
    .state (state),
    .ctrl  (ctrl)
  );

`ifdef ARM_MC_MEM_WAIT_EN
  // Only memory-port states stall; elsewhere mem_go is don't-care
  assign mem_go = is_mem_state(state) ? mem_ready : 1'b1;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go           = 1'b1;
`endif

  // Select outputs straight from the decode; strobes also gated by reset and the memory handshake
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ALUOp     = ctrl.alu_op;
  assign IRWrite   = ctrl.ir_write & mem_go & reset;
  assign NextPC    = ctrl.next_pc  & mem_go & reset;
  assign MemW      = ctrl.mem_w    & mem_go & reset;
  assign RegW      = ctrl.reg_w    & reset;
  assign Branch    = ctrl.branch   & reset;
  assign state_o   = state;

  // Next-state, retire counter and illegal-op pulse
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      instr_count <= '0;
      illegal     <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        FETCH:  if (mem_go) state <= DECODE;
        DECODE: begin
          case (op)
            OP_MEM:  state <= MEMADR;
            OP_DP:   state <= funct[5] ? EXECI : EXECR;
            OP_BR:   state <= BRANCH;
            default: begin
              state   <= FETCH;
              illegal <= 1'b1;
            end
          endcase
        end
        MEMADR: state <= funct[0] ? MEMRD : MEMWR;
        MEMRD:  if (mem_go) state <= MEMWB;
        MEMWR: begin
          if (mem_go) begin
            state       <= FETCH;
            instr_count <= instr_count + CNT_W'(1);
          end
        end
        EXECR, EXECI: state <= ALUWB;
        MEMWB, ALUWB, BRANCH: begin
          state       <= FETCH;
          instr_count <= instr_count + CNT_W'(1);
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_mc_main_fsm.sv
// Bench for arm_mc_main_fsm: instruction-level model builds the expected per-cycle
// trace, one compare process checks it each negedge, plus literal pin checks.
module tb_arm_mc_main_fsm;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [5:0]       funct = 6'b0;
  logic             mem_ready = 1'b1;
  logic             IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch, illegal;
  logic [1:0]       ALUSrcB, ResultSrc;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instr_count;

  arm_mc_main_fsm #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .illegal(illegal), .state_o(state_o),
    .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]       st;
    logic             irw, npc, adr, srca, aluop, regw, memw, br, ill;
    logic [1:0]       srcb, res;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             q[$];
  int               n_chk = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] m_cnt = '0;   // instructions retired so far (model)
  bit               m_ill = 1'b0; // an illegal op just finished decoding

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for one instruction step, straight from the state table
  function automatic exp_t step_exp(input int s);
    exp_t e;
    e = '{default: '0};
    e.st = 4'(s);
    case (s)
      0: begin e.irw = 1; e.npc = 1; e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; end
      1: begin e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; end
      2: e.srcb = 2'b01;
      3: e.adr = 1;
      4: begin e.res = 2'b01; e.regw = 1; end
      5: begin e.adr = 1; e.memw = 1; end
      6: begin e.srcb = 2'b00; e.aluop = 1; end
      7: begin e.srcb = 2'b01; e.aluop = 1; end
      8: e.regw = 1;
      9: begin e.srcb = 2'b01; e.res = 2'b10; e.br = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Queue one expected cycle and let it elapse
  task automatic tick_exp(input int s, input bit ready);
    exp_t e;
    e = step_exp(s);
    if (!ready) begin e.irw = 0; e.npc = 0; e.memw = 0; end
    e.ill = m_ill;
    m_ill = 1'b0;
    e.cnt = m_cnt;
    q.push_back(e);
    @(posedge CLK); #1;
  endtask

  // Run one whole instruction; waits = memory-not-ready cycles at fetch
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input int waits);
    int seq[$];
    case (o)
      2'b01:   seq = f[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
      2'b00:   seq = f[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
      2'b10:   seq = '{0, 1, 9};
      default: seq = '{0, 1};
    endcase
    op = o;
    funct = f;
`ifdef ARM_MC_MEM_WAIT_EN
    mem_ready = 1'b0;
    repeat (waits) tick_exp(0, 1'b0);
    mem_ready = 1'b1;
`else
    mem_ready = (waits == 0);
`endif
    foreach (seq[i]) tick_exp(seq[i], 1'b1);
    mem_ready = 1'b1;
    if (o == 2'b11) m_ill = 1'b1;
    else            m_cnt = m_cnt + 1'b1;
  endtask

  // Compare process: every cycle with a queued expectation
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state_o", state_o, e.st);
      chk("IRWrite", IRWrite, e.irw);
      chk("NextPC", NextPC, e.npc);
      chk("AdrSrc", AdrSrc, e.adr);
      chk("ALUSrcA", ALUSrcA, e.srca);
      chk("ALUSrcB", ALUSrcB, e.srcb);
      chk("ResultSrc", ResultSrc, e.res);
      chk("ALUOp", ALUOp, e.aluop);
      chk("RegW", RegW, e.regw);
      chk("MemW", MemW, e.memw);
      chk("Branch", Branch, e.br);
      chk("illegal", illegal, e.ill);
      chk("instr_count", instr_count, e.cnt);
    end
  end

  initial begin
    // Reset held from time 0
    #2;
    chk("rst_state", state_o, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_IRWrite", IRWrite, 0);
    chk("rst_NextPC", NextPC, 0);
    @(posedge CLK); #1;
    reset = 1'b1;

    // One ADD so the abort below has a nonzero count to clear
    run_instr(2'b00, 6'b001000, 0);
    chk("add_count", instr_count, 1);

    // LDR aborted by reset in MEMRD
    op = 2'b01; funct = 6'b011001;
    tick_exp(0, 1); tick_exp(1, 1); tick_exp(2, 1);
    chk("pre_abort_state", state_o, 3);
    reset = 1'b0;
    #1;
    chk("abort_state", state_o, 0);
    chk("abort_count", instr_count, 0);
    chk("abort_MemW", MemW, 0);
    chk("abort_RegW", RegW, 0);
    m_cnt = '0;
    m_ill = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("rst_hold_IRWrite", IRWrite, 0);
      chk("rst_hold_NextPC", NextPC, 0);
    end
    @(posedge CLK); #1;
    reset = 1'b1;

    // One of each instruction class
    run_instr(2'b00, 6'b001000, 0);  // ADD reg
    run_instr(2'b00, 6'b101000, 0);  // ADD imm
    run_instr(2'b01, 6'b011001, 0);  // LDR
    run_instr(2'b01, 6'b011000, 0);  // STR
    run_instr(2'b10, 6'b000000, 0);  // B
    chk("five_count", instr_count, 5);
    run_instr(2'b11, 6'b000000, 0);  // illegal
    chk("illegal_pulse", illegal, 1);
    chk("illegal_fetch", state_o, 0);
    chk("illegal_count", instr_count, 5);

    // Fill to 15, then wrap
    repeat (10) run_instr(2'b00, 6'b001000, 0);
    chk("count_15", instr_count, 15);
    run_instr(2'b00, 6'b001000, 0);
    chk("count_wrap", instr_count, 0);

    // Memory not ready for 3 cycles at fetch
    run_instr(2'b00, 6'b001000, 3);
    chk("wait_count", instr_count, 1);
    run_instr(2'b10, 6'b000000, 0);
    chk("final_count", instr_count, 2);

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
